branch_predictor_table: RTL and testbench
=========================================

Name: branch_predictor_table

Overview:
- Parametrised successor to the single-FSM branch predictor: a direct-mapped table of saturating counters, indexed by PC, with an optional gshare global-history mode.
- Lookup occurs in Decode using the IF/ID PC and the immediate; it returns taken/not-taken and the target (pc + imm).
- Update occurs in MEM from the resolved branch decision.
- Includes branch and mispredict performance counters for logging.

Parameters:
- INDEX_BITS, 4, log2 of table depth (DEPTH = 2^INDEX_BITS entries); range 1..10.
- CTR_BITS, 2, saturating counter width; range 1..4.
- GSHARE, 0, 0 = index from PC only; 1 = index is PC bits XOR global history.
- HIST_BITS, 4, global history register width; must be <= INDEX_BITS; ignored when GSHARE=0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low. One clock; reset is synchronous and active-low.
- lookup_valid  in  1  decode-stage branch control signal.
- lookup_pc  in  32  PC of the decode-stage instruction.
- lookup_offset  in  32  sign-extended branch immediate.
- prediction  out  1  predict taken.
- branch_addr  out  32  predicted target.
- pred_index  out  INDEX_BITS  table index used for this lookup; carried down the pipeline.
- update_valid  in  1  MEM-stage branch control signal.
- update_index  in  INDEX_BITS  pred_index returned from MEM.
- update_taken  in  1  actual branch decision.
- update_mispredict  in  1  prediction differed from outcome.
- branch_count  out  32  resolved branches since reset.
- mispredict_count  out  32  mispredictions since reset.

Behaviour:
- Index calculation:
  - base = lookup_pc[INDEX_BITS+1:2].
  - GSHARE=1: pred_index = base XOR {zero-extend ghr}.
  - GSHARE=0: pred_index = base.
- Lookup is combinational (zero latency):
  - prediction = lookup_valid & rst_n & ctr[pred_index][CTR_BITS-1].
  - branch_addr = lookup_pc + lookup_offset, modulo 2^32, valid whenever lookup_valid is high; don't-care otherwise.
- Counter update (posedge clk, rst_n=1, update_valid=1):
  - update_taken=1: ctr[update_index] increments, saturating at 2^CTR_BITS-1.
  - update_taken=0: ctr[update_index] decrements, saturating at 0.
  - No other entry changes.
- Global history (GSHARE=1 only):
  - On update_valid, ghr <= {ghr[HIST_BITS-2:0], update_taken}. History is non-speculative.
  - With HIST_BITS=1, ghr <= update_taken.
- Same-cycle lookup and update to the same index: lookup uses the pre-update counter and pre-update ghr. There is no bypass; the new value is visible next cycle.
- Performance counters:
  - On each update_valid: branch_count += 1.
  - If update_mispredict is also high: mispredict_count += 1.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
  - update_mispredict is ignored when update_valid=0.
- Reset (rst_n=0 at posedge):
  - Every ctr <= 2^(CTR_BITS-1)-1, i.e. weakly not-taken (2'b01 for CTR_BITS=2; 0 for CTR_BITS=1).
  - ghr <= 0; branch_count <= 0; mispredict_count <= 0.
  - prediction is forced to 0 while rst_n=0.
  - Reset asserted in the same cycle as update_valid: reset wins and the update is discarded.
- Flush: the predictor holds no in-flight state. A squashed branch is simply never updated; the pipeline gates update_valid.
- Storage: flops, not BRAM. No X may appear on any output after the first reset edge.

Test Plan:
1. Reset, then lookup_valid=1, lookup_pc=0x40, lookup_offset=0xFFFF_FFF0 -> prediction=0, branch_addr=0x30, pred_index=0.
2. Three updates index=0 taken=1 -> ctr sequence 01→10→11→11 (saturated); lookup pc=0x40 -> prediction=1 from the 1st update onward. Then two updates taken=0 -> 11→10→01 -> prediction=0.
3. Same-cycle collision at index 5 (ctr=01): update taken=1 while looking up pc=0x14 -> prediction=0 that cycle, 1 the next cycle.
4. GSHARE=1, HIST_BITS=4: updates taken 1,0,1,1 -> ghr=4'b1011; lookup pc=0x8 (base=2) -> pred_index=4'b1001. Pulse rst_n=0 for one cycle -> ghr=0, pred_index=2.
5. Counters: 10 updates with 3 mispredicts -> branch_count=10, mispredict_count=3. update_mispredict=1 with update_valid=0 -> no change. Force branch_count=0xFFFF_FFFF, then update -> stays 0xFFFF_FFFF.
6. lookup_valid=0 with a strongly-taken entry -> prediction=0. rst_n=0 together with update_valid=1 -> counter returns to 01.

Source files
------------

// File: rtl/branch_predictor_table.sv
// branch_predictor_table
// Direct-mapped table of saturating counters, indexed by PC with an optional
// gshare global-history mode. It is looked up in Decode and updated in MEM.
// Ports:
//   clk, rst_n              rising-edge clock, synchronous active-low reset
//   lookup_valid/pc/offset  decode-stage lookup request
//   prediction              predict taken (combinational)
//   branch_addr             predicted target, lookup_pc + lookup_offset
//   pred_index              table index used; carried down to MEM
//   update_valid/index      MEM-stage resolved branch and its table index
//   update_taken            actual branch decision
//   update_mispredict       prediction differed from outcome
//   branch_count            resolved branches since reset (saturating)
//   mispredict_count        mispredictions since reset (saturating)
module branch_predictor_table #(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int GSHARE     = 0,
  parameter int HIST_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  input  logic [31:0]           lookup_offset,
  output logic                  prediction,
  output logic [31:0]           branch_addr,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  // Weakly not-taken: all ones shifted right gives 2^(CTR_BITS-1)-1.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1'b1);
  localparam logic [31:0]         CNT_MAX  = 32'hFFFF_FFFF;

  logic [CTR_BITS-1:0]   ctr_r [DEPTH];
  logic [31:0]           branch_count_r;
  logic [31:0]           mispredict_count_r;
  logic [INDEX_BITS-1:0] base_s;
  logic [INDEX_BITS-1:0] hist_ext_s;
  logic [INDEX_BITS-1:0] index_s;

  assign base_s = lookup_pc[INDEX_BITS+1:2];

  generate
    if (GSHARE != 0) begin : g_gshare
      logic [HIST_BITS-1:0] ghr_r;

      // Non-speculative global history, shifted on every resolved branch.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ghr_r <= {HIST_BITS{1'b0}};
        end else if (update_valid) begin
          if (HIST_BITS == 1) begin
            ghr_r <= HIST_BITS'(update_taken);
          end else begin
            ghr_r <= HIST_BITS'({ghr_r, update_taken});
          end
        end else begin
          ghr_r <= ghr_r;
        end
      end

      assign hist_ext_s = INDEX_BITS'(ghr_r);
    end else begin : g_pc_only
      assign hist_ext_s = {INDEX_BITS{1'b0}};
    end
  endgenerate

  // Lookup index and prediction; uses pre-update state, no bypass.
  always_comb begin
    index_s     = base_s ^ hist_ext_s;
    pred_index  = index_s;
    branch_addr = lookup_pc + lookup_offset;
    if (lookup_valid && rst_n) begin
      prediction = ctr_r[index_s][CTR_BITS-1];
    end else begin
      prediction = 1'b0;
    end
  end

  // Saturating counter table; reset discards a coincident update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_r[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      if (update_taken) begin
        if (ctr_r[update_index] != CTR_MAX) begin
          ctr_r[update_index] <= ctr_r[update_index] + CTR_ONE;
        end
      end else begin
        if (ctr_r[update_index] != {CTR_BITS{1'b0}}) begin
          ctr_r[update_index] <= ctr_r[update_index] - CTR_ONE;
        end
      end
    end
  end

  // Performance counters, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (update_valid) begin
      if (branch_count_r != CNT_MAX) begin
        branch_count_r <= branch_count_r + 32'd1;
      end
      if (update_mispredict && (mispredict_count_r != CNT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end
    end
  end

  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predictor_table.sv
module tb_branch_predictor_table;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [31:0] lookup_offset;
  logic        update_valid;
  logic [3:0]  update_index;
  logic        update_taken;
  logic        update_mispredict;

  logic        prediction_a, prediction_b;
  logic [31:0] branch_addr_a, branch_addr_b;
  logic [3:0]  pred_index_a, pred_index_b;
  logic [31:0] branch_count_a, branch_count_b;
  logic [31:0] mispredict_count_a, mispredict_count_b;

  int checks;
  int failures;

  branch_predictor_table #(.INDEX_BITS(4), .CTR_BITS(2), .GSHARE(0), .HIST_BITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_offset(lookup_offset),
    .prediction(prediction_a), .branch_addr(branch_addr_a), .pred_index(pred_index_a),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .branch_count(branch_count_a), .mispredict_count(mispredict_count_a)
  );

  branch_predictor_table #(.INDEX_BITS(4), .CTR_BITS(2), .GSHARE(1), .HIST_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_offset(lookup_offset),
    .prediction(prediction_b), .branch_addr(branch_addr_b), .pred_index(pred_index_b),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .branch_count(branch_count_b), .mispredict_count(mispredict_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    update_valid = 1'b0;
    update_mispredict = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic upd(input logic [3:0] idx, input logic taken, input logic mis);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = taken;
    update_mispredict = mis;
    @(negedge clk);
    update_valid = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic [31:0] off);
    lookup_valid = 1'b1;
    lookup_pc = pc;
    lookup_offset = off;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    look(32'h0000_0040, 32'hFFFF_FFF0);
    checks++;
    if (prediction_a !== 1'b0) begin
      failures++; $display("FAIL reset_pred: got %0b expected 0", prediction_a);
    end
    checks++;
    if (branch_addr_a !== 32'h0000_0030) begin
      failures++; $display("FAIL reset_addr: got %08h expected 00000030", branch_addr_a);
    end
    checks++;
    if (pred_index_a !== 4'd0) begin
      failures++; $display("FAIL reset_index: got %0d expected 0", pred_index_a);
    end
    checks++;
    if (branch_count_a !== 32'd0 || mispredict_count_a !== 32'd0) begin
      failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", branch_count_a, mispredict_count_a);
    end
    look(32'hFFFF_FFFC, 32'h0000_0008);
    checks++;
    if (branch_addr_a !== 32'h0000_0004) begin
      failures++; $display("FAIL addr_wrap: got %08h expected 00000004", branch_addr_a);
    end
  endtask

  task automatic test_saturate();
    logic exp_taken [9];
    logic dir [9];
    do_reset();
    // 01 ->10 ->11 ->11 ->10 ->01 ->00 ->00 ->01 ->10
    dir       = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_taken = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      upd(4'd0, dir[i], 1'b0);
      look(32'h0000_0040, 32'h0000_0010);
      checks++;
      if (prediction_a !== exp_taken[i]) begin
        failures++; $display("FAIL saturate_step%0d: got %0b expected %0b", i, prediction_a, exp_taken[i]);
      end
    end
    look(32'h0000_0044, 32'h0000_0010);
    checks++;
    if (prediction_a !== 1'b0) begin
      failures++; $display("FAIL other_entry: got %0b expected 0", prediction_a);
    end
  endtask

  task automatic test_collision();
    do_reset();
    @(negedge clk);
    update_valid = 1'b1;
    update_index = 4'd5;
    update_taken = 1'b1;
    look(32'h0000_0014, 32'h0000_0000);
    checks++;
    if (prediction_a !== 1'b0 || pred_index_a !== 4'd5) begin
      failures++; $display("FAIL collision_same: got pred %0b idx %0d expected 0 idx 5", prediction_a, pred_index_a);
    end
    @(negedge clk);
    update_valid = 1'b0;
    #1;
    checks++;
    if (prediction_a !== 1'b1) begin
      failures++; $display("FAIL collision_next: got %0b expected 1", prediction_a);
    end
  endtask

  task automatic test_gshare();
    do_reset();
    upd(4'd0, 1'b1, 1'b0);
    look(32'h0000_0008, 32'h0000_0000);
    checks++;
    if (pred_index_b !== 4'b0011) begin
      failures++; $display("FAIL ghr_one: got %04b expected 0011", pred_index_b);
    end
    upd(4'd0, 1'b0, 1'b0);
    upd(4'd0, 1'b1, 1'b0);
    upd(4'd0, 1'b1, 1'b0);
    look(32'h0000_0008, 32'h0000_0000);
    checks++;
    if (pred_index_b !== 4'b1001) begin
      failures++; $display("FAIL ghr_1011: got %04b expected 1001", pred_index_b);
    end
    checks++;
    if (pred_index_a !== 4'b0010) begin
      failures++; $display("FAIL pc_only_index: got %04b expected 0010", pred_index_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (pred_index_b !== 4'b0010) begin
      failures++; $display("FAIL ghr_reset: got %04b expected 0010", pred_index_b);
    end
  endtask

  task automatic test_counters();
    logic mis [10];
    do_reset();
    mis = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      upd(4'(i), i[0], mis[i]);
    end
    #1;
    checks++;
    if (branch_count_a !== 32'd10 || mispredict_count_a !== 32'd3) begin
      failures++; $display("FAIL counts_10_3: got %0d/%0d expected 10/3", branch_count_a, mispredict_count_a);
    end
    update_mispredict = 1'b1;
    @(negedge clk);
    update_mispredict = 1'b0;
    #1;
    checks++;
    if (branch_count_a !== 32'd10 || mispredict_count_a !== 32'd3) begin
      failures++; $display("FAIL counts_gated: got %0d/%0d expected 10/3", branch_count_a, mispredict_count_a);
    end
    force dut_a.branch_count_r = 32'hFFFF_FFFF;
    #1;
    release dut_a.branch_count_r;
    @(negedge clk);
    upd(4'd1, 1'b1, 1'b1);
    #1;
    checks++;
    if (branch_count_a !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL count_saturate: got %08h expected ffffffff", branch_count_a);
    end
    checks++;
    if (mispredict_count_a !== 32'd4) begin
      failures++; $display("FAIL mis_after_sat: got %0d expected 4", mispredict_count_a);
    end
  endtask

  task automatic test_valid_and_reset();
    do_reset();
    upd(4'd3, 1'b1, 1'b0);
    upd(4'd3, 1'b1, 1'b0);
    lookup_valid = 1'b0;
    lookup_pc = 32'h0000_000C;
    #1;
    checks++;
    if (prediction_a !== 1'b0) begin
      failures++; $display("FAIL lookup_invalid: got %0b expected 0", prediction_a);
    end
    look(32'h0000_000C, 32'h0000_0000);
    checks++;
    if (prediction_a !== 1'b1) begin
      failures++; $display("FAIL strong_taken: got %0b expected 1", prediction_a);
    end
    // Reset together with an update: prediction forced low, update lost.
    rst_n = 1'b0;
    update_valid = 1'b1;
    update_index = 4'd3;
    update_taken = 1'b1;
    #1;
    checks++;
    if (prediction_a !== 1'b0) begin
      failures++; $display("FAIL pred_in_reset: got %0b expected 0", prediction_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    update_valid = 1'b0;
    #1;
    checks++;
    if (prediction_a !== 1'b0 || branch_count_a !== 32'd0) begin
      failures++; $display("FAIL reset_wins: got pred %0b cnt %0d expected 0 cnt 0", prediction_a, branch_count_a);
    end
    @(negedge clk);
    upd(4'd3, 1'b1, 1'b0);
    look(32'h0000_000C, 32'h0000_0000);
    checks++;
    if (prediction_a !== 1'b1) begin
      failures++; $display("FAIL weak_after_reset: got %0b expected 1", prediction_a);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc = 32'd0;
    lookup_offset = 32'd0;
    update_valid = 1'b0;
    update_index = 4'd0;
    update_taken = 1'b0;
    update_mispredict = 1'b0;
    test_reset();
    test_saturate();
    test_collision();
    test_gshare();
    test_counters();
    test_valid_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
